// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for the hazard/forwarding controller: register fields and
// stage flags in, forwarding selects and stall/flush controls out.
interface hazard_forward_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic [REG_BITS-1:0] ex_rs;
  logic [REG_BITS-1:0] ex_rt;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_mem_read;
  logic                ex_branch_taken;
  logic                ex_mult_start;
  logic [REG_BITS-1:0] mem_rd;
  logic                mem_reg_write;
  logic [REG_BITS-1:0] wb_rd;
  logic                wb_reg_write;

  logic [1:0]          fwd_a_sel;
  logic [1:0]          fwd_b_sel;
  logic                pc_write;
  logic                if_id_write;
  logic                id_ex_bubble;
  logic                if_id_flush;
  logic                mult_busy;
  logic [CNT_BITS-1:0] stall_count;
  logic [CNT_BITS-1:0] flush_count;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read, ex_branch_taken,
           ex_mult_start, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    input  fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_bubble,
           if_id_flush, mult_busy, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read, ex_branch_taken,
           ex_mult_start, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    output fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_bubble,
           if_id_flush, mult_busy, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: ALU operand forwarding,
// load-use stalls, branch flushes, multiplier freeze and saturating perf counters.
module hazard_forward_ctrl #(
  parameter int REG_BITS     = 5,
  parameter int MULT_LATENCY = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hazard_forward_ctrl_if.slave  hz
);

  typedef enum logic {RUN, MULT_WAIT} state_t;

  localparam logic [3:0] MULT_INIT = 4'(MULT_LATENCY - 1);

  state_t              state;
  logic [3:0]          mult_cnt;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  logic                load_use;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic                pc_write;
  logic                if_id_write;
  logic                bubble;
  logic                flush;
  logic                busy;

  // MEM wins over WB because it holds the younger result; register 0 never forwards.
  function automatic logic [1:0] fwd_code(
    input logic [REG_BITS-1:0] src,
    input logic [REG_BITS-1:0] mem_rd,
    input logic                mem_w,
    input logic [REG_BITS-1:0] wb_rd,
    input logic                wb_w
  );
    if (mem_w && (mem_rd != '0) && (mem_rd == src))
      return 2'd1;
    else if (wb_w && (wb_rd != '0) && (wb_rd == src))
      return 2'd2;
    return 2'd0;
  endfunction

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;
    busy        = 1'b0;
    fwd_a       = 2'd0;
    fwd_b       = 2'd0;
    if (reset_n) begin
      fwd_a = fwd_code(hz.ex_rs, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
      fwd_b = fwd_code(hz.ex_rt, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
      if (state == MULT_WAIT) begin
        busy        = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        bubble      = 1'b1;
      end else if (hz.ex_branch_taken) begin
        // The ID instruction is wrong-path, so the flush supersedes any load-use stall.
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        bubble      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      mult_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_BITS'(1);
      case (state)
        RUN: begin
          if (hz.ex_mult_start) begin
            state    <= MULT_WAIT;
            mult_cnt <= MULT_INIT;
          end
        end
        MULT_WAIT: begin
          // Leaving on count 1 freezes the front end for MULT_LATENCY-1 cycles.
          if (mult_cnt <= 4'd1) begin
            state    <= RUN;
            mult_cnt <= '0;
          end else begin
            mult_cnt <= mult_cnt - 4'd1;
          end
        end
        default: begin
          state    <= RUN;
          mult_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.fwd_a_sel    = fwd_a;
  assign hz.fwd_b_sel    = fwd_b;
  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_bubble = bubble;
  assign hz.if_id_flush  = flush;
  assign hz.mult_busy    = busy;
  assign hz.stall_count  = stall_cnt;
  assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: table of single-cycle RUN vectors followed by
// hand-written multiply, reset-during-multiply and counter saturation sequences.
module tb_hazard_forward_ctrl;

  localparam int RB = 5;
  localparam int CB = 4;
  localparam int ML = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   exp_stall;
  int   exp_flush;

  hazard_forward_ctrl_if #(.REG_BITS(RB), .CNT_BITS(CB)) hz ();

  hazard_forward_ctrl #(.REG_BITS(RB), .MULT_LATENCY(ML), .CNT_BITS(CB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RB-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd;
    logic          mem_read, br;
    logic [RB-1:0] mem_rd;
    logic          mem_w;
    logic [RB-1:0] wb_rd;
    logic          wb_w;
    logic [1:0]    ea, eb;
    logic          epc, eifid, ebub, eflush;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkVec(
    input int id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_read, br,
    input int mem_rd, mem_w, wb_rd, wb_w,
    input int ea, eb, epc, eifid, ebub, eflush
  );
    vec_t v;
    v.id_rs = RB'(id_rs); v.id_rt = RB'(id_rt);
    v.ex_rs = RB'(ex_rs); v.ex_rt = RB'(ex_rt); v.ex_rd = RB'(ex_rd);
    v.mem_read = 1'(mem_read); v.br = 1'(br);
    v.mem_rd = RB'(mem_rd); v.mem_w = 1'(mem_w);
    v.wb_rd = RB'(wb_rd); v.wb_w = 1'(wb_w);
    v.ea = 2'(ea); v.eb = 2'(eb);
    v.epc = 1'(epc); v.eifid = 1'(eifid); v.ebub = 1'(ebub); v.eflush = 1'(eflush);
    return v;
  endfunction

  task automatic clearInputs();
    hz.id_rs = '0; hz.id_rt = '0; hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_rd = '0;
    hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.ex_mult_start = 1'b0;
    hz.mem_rd = '0; hz.mem_reg_write = 1'b0; hz.wb_rd = '0; hz.wb_reg_write = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    hz.id_rs = v.id_rs; hz.id_rt = v.id_rt;
    hz.ex_rs = v.ex_rs; hz.ex_rt = v.ex_rt; hz.ex_rd = v.ex_rd;
    hz.ex_mem_read = v.mem_read; hz.ex_branch_taken = v.br; hz.ex_mult_start = 1'b0;
    hz.mem_rd = v.mem_rd; hz.mem_reg_write = v.mem_w;
    hz.wb_rd = v.wb_rd; hz.wb_reg_write = v.wb_w;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  task automatic checkComb(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic epc, input logic eifid, input logic ebub,
                           input logic eflush, input logic ebusy);
    checkOutput({tag, ".fwd_a"}, 16'(hz.fwd_a_sel), 16'(ea));
    checkOutput({tag, ".fwd_b"}, 16'(hz.fwd_b_sel), 16'(eb));
    checkOutput({tag, ".pc_write"}, 16'(hz.pc_write), 16'(epc));
    checkOutput({tag, ".if_id_write"}, 16'(hz.if_id_write), 16'(eifid));
    checkOutput({tag, ".bubble"}, 16'(hz.id_ex_bubble), 16'(ebub));
    checkOutput({tag, ".flush"}, 16'(hz.if_id_flush), 16'(eflush));
    checkOutput({tag, ".mult_busy"}, 16'(hz.mult_busy), 16'(ebusy));
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".stall_count"}, 16'(hz.stall_count), 16'(exp_stall));
    checkOutput({tag, ".flush_count"}, 16'(hz.flush_count), 16'(exp_flush));
  endtask

  // Advance one clock using the expected controls of the cycle just checked.
  task automatic tick(input string tag, input logic epc, input logic eflush);
    if (!epc && exp_stall != (1 << CB) - 1) exp_stall++;
    if (eflush && exp_flush != (1 << CB) - 1) exp_flush++;
    @(posedge clk);
    #1;
    checkCounters(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    exp_flush = 0;

    //           id_rs rt ex_rs rt rd mr br  mrd mw wrd ww   ea eb pc ifid bub fl
    vecs[0]  = mkVec(0, 0, 3, 3, 0, 0, 0,   3, 1, 3, 1,   1, 1, 1, 1, 0, 0);
    vecs[1]  = mkVec(0, 0, 3, 3, 0, 0, 0,   3, 0, 3, 1,   2, 2, 1, 1, 0, 0);
    vecs[2]  = mkVec(0, 0, 3, 3, 0, 0, 0,   0, 1, 0, 1,   0, 0, 1, 1, 0, 0);
    vecs[3]  = mkVec(0, 0, 4, 7, 0, 0, 0,   4, 1, 7, 1,   1, 2, 1, 1, 0, 0);
    vecs[4]  = mkVec(0, 0, 7, 4, 0, 0, 0,   4, 1, 7, 0,   0, 1, 1, 1, 0, 0);
    vecs[5]  = mkVec(0, 5, 0, 0, 5, 1, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    vecs[6]  = mkVec(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
    vecs[7]  = mkVec(9, 2, 0, 0, 9, 1, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    vecs[8]  = mkVec(9, 2, 0, 0, 9, 0, 0,   0, 0, 0, 0,   0, 0, 1, 1, 0, 0);
    vecs[9]  = mkVec(0, 5, 0, 0, 5, 1, 1,   0, 0, 0, 0,   0, 0, 1, 1, 1, 1);
    vecs[10] = mkVec(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,   0, 0, 1, 1, 1, 1);

    // Reset, with a forwarding match present to prove the outputs are forced.
    reset_n = 1'b0;
    clearInputs();
    hz.mem_rd = 5'd3; hz.mem_reg_write = 1'b1; hz.ex_rs = 5'd3;
    @(posedge clk);
    @(negedge clk);
    checkComb("reset", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCounters("reset");
    reset_n = 1'b1;
    clearInputs();

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkComb($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].epc,
                vecs[i].eifid, vecs[i].ebub, vecs[i].eflush, 1'b0);
      tick($sformatf("vec%0d", i), vecs[i].epc, vecs[i].eflush);
    end

    // Multiply issue, then three frozen cycles; a branch and load-use mid-wait are ignored.
    @(negedge clk);
    clearInputs();
    hz.ex_mult_start = 1'b1;
    #1;
    checkComb("mult_issue", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("mult_issue", 1'b1, 1'b0);
    for (int i = 0; i < ML - 1; i++) begin
      @(negedge clk);
      clearInputs();
      if (i == 1) begin
        hz.ex_branch_taken = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rt = 5'd5;
        hz.mem_rd = 5'd6; hz.mem_reg_write = 1'b1; hz.ex_rs = 5'd6;
      end
      #1;
      checkComb($sformatf("mult_wait%0d", i), (i == 1) ? 2'd1 : 2'd0, 2'd0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick($sformatf("mult_wait%0d", i), 1'b0, 1'b0);
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkComb("mult_done", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("mult_done", 1'b1, 1'b0);

    // Branch and multiply issue together: flush now, freeze afterwards.
    @(negedge clk);
    clearInputs();
    hz.ex_branch_taken = 1'b1;
    hz.ex_mult_start = 1'b1;
    #1;
    checkComb("br_mult", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("br_mult", 1'b1, 1'b1);
    for (int i = 0; i < ML - 1; i++) begin
      @(negedge clk);
      clearInputs();
      #1;
      checkComb($sformatf("br_mult_wait%0d", i), 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick($sformatf("br_mult_wait%0d", i), 1'b0, 1'b0);
    end

    // Reset on the second MULT_WAIT cycle.
    @(negedge clk);
    clearInputs();
    hz.ex_mult_start = 1'b1;
    #1;
    checkComb("rst_mult_issue", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("rst_mult_issue", 1'b1, 1'b0);
    @(negedge clk);
    clearInputs();
    #1;
    checkComb("rst_mult_wait0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick("rst_mult_wait0", 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    hz.mem_rd = 5'd3; hz.mem_reg_write = 1'b1; hz.ex_rs = 5'd3; hz.ex_rt = 5'd3;
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs = 5'd5;
    #1;
    checkComb("rst_mid_mult", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    exp_stall = 0;
    exp_flush = 0;
    checkCounters("rst_mid_mult");
    @(negedge clk);
    reset_n = 1'b1;
    clearInputs();
    #1;
    checkComb("post_rst0", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("post_rst0", 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkComb("post_rst1", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("post_rst1", 1'b1, 1'b0);

    // Hold a load-use hazard for 20 cycles; the 4-bit stall counter must stop at 15.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clearInputs();
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs = 5'd7;
      #1;
      checkComb($sformatf("sat%0d", i), 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick($sformatf("sat%0d", i), 1'b0, 1'b0);
    end
    checkOutput("sat_final", 16'(hz.stall_count), 16'd15);

    @(negedge clk);
    clearInputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipeline. Generates the 2-bit select codes for the ALU operand forwarding muxes (mux_2bit) and the stall, bubble and flush controls for the PC, IF/ID and ID/EX registers. Covers load-use hazards, taken branches and a multi-cycle multiply unit through a small FSM. Keeps saturating stall and flush performance counters. Sits beside the ID/EX stages and drives only control signals; it touches no data.

Parameters:
REG_BITS, 5, register address width
MULT_LATENCY, 4, cycles the multiplier occupies EX (legal range 2..15)
CNT_BITS, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock
reset_n  in  1  synchronous active-low reset
id_rs  in  REG_BITS  rs field of the instruction in ID
id_rt  in  REG_BITS  rt field of the instruction in ID
ex_rs  in  REG_BITS  rs of the instruction in EX
ex_rt  in  REG_BITS  rt of the instruction in EX
ex_rd  in  REG_BITS  destination of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_branch_taken  in  1  branch resolved taken in EX
ex_mult_start  in  1  multiply issued in EX this cycle
mem_rd  in  REG_BITS  destination in MEM
mem_reg_write  in  1  MEM stage writes the register file
wb_rd  in  REG_BITS  destination in WB
wb_reg_write  in  1  WB stage writes the register file
fwd_a_sel  out  2  ALU operand A mux select
fwd_b_sel  out  2  ALU operand B mux select
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
id_ex_bubble  out  1  insert a NOP into ID/EX
if_id_flush  out  1  clear IF/ID to a NOP
mult_busy  out  1  multiplier occupying EX
stall_count  out  CNT_BITS  cycles stalled, saturating
flush_count  out  CNT_BITS  flushes issued, saturating

Behaviour:
- Reset: any rising clk with reset_n=0 sets state to RUN, the multiply counter to 0, and both perf counters to 0.
- While reset_n=0, outputs are forced to: pc_write=1, if_id_write=1, bubble=0, flush=0, mult_busy=0, fwd_*_sel=0.
- Forwarding is combinational, same cycle, evaluated for each operand (ex_rs→A, ex_rt→B). Codes:
  - 1 (EX/MEM result): mem_reg_write and mem_rd!=0 and mem_rd==src.
  - 2 (MEM/WB value): otherwise, if wb_reg_write and wb_rd!=0 and wb_rd==src.
  - 0 (register file): otherwise.
  - MEM has priority over WB. Code 3 is never driven.
- Load-use hazard (combinational): ex_mem_read and ex_rd!=0 and (ex_rd==id_rs or ex_rd==id_rt).
- FSM states: RUN, MULT_WAIT.
- RUN, checked in priority order:
  1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. The flush overrides any load-use stall, because the ID instruction is wrong-path.
  2. Load-use: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle; the hazard clears naturally once the bubble advances.
  3. Otherwise all enables are 1 and bubble and flush are 0.
  4. ex_mult_start: go to MULT_WAIT next cycle with counter=MULT_LATENCY-1. This is evaluated together with items 1-3, so branch plus mult_start in the same cycle both flushes and enters MULT_WAIT.
- MULT_WAIT:
  - mult_busy=1, pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - The counter decrements each cycle. When it reaches 1, the next state is RUN.
  - The front end is therefore frozen for exactly MULT_LATENCY-1 cycles after the issue cycle.
  - ex_branch_taken and ex_mult_start are ignored in MULT_WAIT, since EX holds bubbles.
  - Load-use detection is suppressed in MULT_WAIT.
  - Forwarding stays active in every state.
- stall_count increments on every cycle with pc_write=0 and saturates at all-ones.
- flush_count increments on every cycle with if_id_flush=1 and saturates at all-ones.
- Reset asserted during MULT_WAIT: the next state is RUN, and the pipeline is unstalled the cycle after reset deasserts.

Test Plan:
1. Forwarding: mem_rd=3/mem_reg_write=1, wb_rd=3/wb_reg_write=1, ex_rs=3, ex_rt=3 → fwd_a_sel=1, fwd_b_sel=1. Clear mem_reg_write → both 2. Set mem_rd=wb_rd=0 → both 0.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rt=5 → for one cycle pc_write=0, if_id_write=0, id_ex_bubble=1, stall_count 0→1. With ex_rd=0 → no stall.
3. Branch beats stall: load-use condition plus ex_branch_taken=1 in the same cycle → if_id_flush=1, pc_write=1, flush_count=1, stall_count unchanged.
4. Multiply: ex_mult_start pulse with MULT_LATENCY=4 → mult_busy=1 for exactly 3 cycles, pc_write=0 over those cycles, stall_count=3, then RUN. A branch raised mid-wait produces no flush.
5. Reset mid-multiply: assert reset_n=0 on the second MULT_WAIT cycle → outputs take reset values that cycle; after release, state is RUN and the counters are 0.
6. Saturation with CNT_BITS=4: hold a load-use hazard for 20 cycles → stall_count stops at 15.
